// File: rtl/pattern_gen_anim.sv
`default_nettype none
// ============================================================================
// Module   : pattern_gen_anim
// Purpose  : Animated RGB565 test-pattern source with frame-aligned config
//            handshake and fixed two-cycle pixel latency.
// Options  : define PATTERN_BORDER_EN for a white one-pixel frame border.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_gen_anim #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int NUM_BARS  = 8,
    parameter int GRID_LOG2 = 5,
    parameter int FC_W      = 16
) (
    input  logic            clk_pixel,
    input  logic            rst,
    input  logic [X_W-1:0]  pixel_x,
    input  logic [Y_W-1:0]  pixel_y,
    input  logic            data_enable,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [3:0]      cfg_pattern,
    input  logic [15:0]     cfg_color,
    input  logic [3:0]      cfg_speed,
    output logic [15:0]     rgb565,
    output logic            rgb565_valid,
    output logic [FC_W-1:0] frame_count
);

    localparam int c_BAR_W = H_ACTIVE / NUM_BARS;
    localparam int c_BC_W  = (c_BAR_W > 1) ? $clog2(c_BAR_W) : 1;
    localparam int c_BI_W  = 4;
    localparam int c_SP_W  = $clog2(H_ACTIVE);
    localparam int c_GA_W  = $clog2(H_ACTIVE + 32);

    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(c_BAR_W - 1);
    localparam logic [c_BI_W-1:0] c_BI_LAST = c_BI_W'(NUM_BARS - 1);
    localparam logic [c_SP_W-1:0] c_SP_LAST = c_SP_W'(H_ACTIVE - 1);

    localparam logic [3:0] c_PAT_BARS    = 4'd0;
    localparam logic [3:0] c_PAT_RED     = 4'd1;
    localparam logic [3:0] c_PAT_GREEN   = 4'd2;
    localparam logic [3:0] c_PAT_GRID    = 4'd3;
    localparam logic [3:0] c_PAT_CHECK   = 4'd4;
    localparam logic [3:0] c_PAT_SOLID   = 4'd5;
    localparam logic [3:0] c_PAT_SCROLL  = 4'd6;
    localparam logic [3:0] c_PAT_LINE    = 4'd7;
    localparam logic [3:0] c_PAT_FLICKER = 4'd8;

    function automatic logic [15:0] f_bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    f_bar_color = 16'hFFFF;
            3'd1:    f_bar_color = 16'hFFE0;
            3'd2:    f_bar_color = 16'h07FF;
            3'd3:    f_bar_color = 16'h07E0;
            3'd4:    f_bar_color = 16'hF81F;
            3'd5:    f_bar_color = 16'hF800;
            3'd6:    f_bar_color = 16'h001F;
            default: f_bar_color = 16'h0000;
        endcase
    endfunction

    logic w_fs, w_ls, w_apply;
    assign w_fs    = data_enable && (pixel_x == '0) && (pixel_y == '0);
    assign w_ls    = data_enable && (pixel_x == '0);

    // ---------------- configuration handshake ----------------
    logic        r_cfg_ready;
    logic [3:0]  r_sh_pattern, r_act_pattern;
    logic [15:0] r_sh_color, r_act_color;
    logic [3:0]  r_sh_speed, r_act_speed;

    assign w_apply   = w_fs && !r_cfg_ready;
    assign cfg_ready = r_cfg_ready;

    // The fs pixel itself already sees the newly applied configuration.
    logic [3:0]  w_pattern;
    logic [15:0] w_color;
    logic [3:0]  w_speed;
    assign w_pattern = w_apply ? r_sh_pattern : r_act_pattern;
    assign w_color   = w_apply ? r_sh_color   : r_act_color;
    assign w_speed   = w_apply ? r_sh_speed   : r_act_speed;

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_cfg_ready   <= 1'b1;
            r_sh_pattern  <= 4'd0;
            r_sh_color    <= 16'hFFFF;
            r_sh_speed    <= 4'd0;
            r_act_pattern <= 4'd0;
            r_act_color   <= 16'hFFFF;
            r_act_speed   <= 4'd0;
        end else if (w_apply) begin
            r_act_pattern <= r_sh_pattern;
            r_act_color   <= r_sh_color;
            r_act_speed   <= r_sh_speed;
            r_cfg_ready   <= 1'b1;
        end else if (cfg_valid && r_cfg_ready) begin
            r_sh_pattern  <= cfg_pattern;
            r_sh_color    <= cfg_color;
            r_sh_speed    <= cfg_speed;
            r_cfg_ready   <= 1'b0;
        end
    end

    // ---------------- animation state ----------------
    logic [FC_W-1:0]   r_frame_count;
    logic [3:0]        r_div;
    logic [c_SP_W-1:0] r_scroll_pos, r_view_pos;
    logic [c_BI_W-1:0] r_scroll_bar, r_view_bar;
    logic [c_BC_W-1:0] r_scroll_off, r_view_off;
    logic              r_view_fc0;

    assign frame_count = r_frame_count;

    // A frame displays the animation state as it stood just before its fs.
    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_div         <= 4'd0;
            r_scroll_pos  <= '0;
            r_scroll_bar  <= '0;
            r_scroll_off  <= '0;
            r_view_pos    <= '0;
            r_view_bar    <= '0;
            r_view_off    <= '0;
            r_view_fc0    <= 1'b0;
        end else if (w_fs) begin
            r_frame_count <= r_frame_count + FC_W'(1);
            r_view_pos    <= r_scroll_pos;
            r_view_bar    <= r_scroll_bar;
            r_view_off    <= r_scroll_off;
            r_view_fc0    <= r_frame_count[0];
            if (r_div >= w_speed) begin
                r_div <= 4'd0;
                if (r_scroll_pos == c_SP_LAST) begin
                    r_scroll_pos <= '0;
                    r_scroll_bar <= '0;
                    r_scroll_off <= '0;
                end else begin
                    r_scroll_pos <= r_scroll_pos + c_SP_W'(1);
                    if (r_scroll_off == c_BC_LAST) begin
                        r_scroll_off <= '0;
                        r_scroll_bar <= (r_scroll_bar == c_BI_LAST) ? '0 : r_scroll_bar + c_BI_W'(1);
                    end else begin
                        r_scroll_off <= r_scroll_off + c_BC_W'(1);
                    end
                end
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    logic [c_SP_W-1:0] w_v_pos;
    logic [c_BI_W-1:0] w_v_bar;
    logic [c_BC_W-1:0] w_v_off;
    logic              w_v_fc0;
    assign w_v_pos = w_fs ? r_scroll_pos     : r_view_pos;
    assign w_v_bar = w_fs ? r_scroll_bar     : r_view_bar;
    assign w_v_off = w_fs ? r_scroll_off     : r_view_off;
    assign w_v_fc0 = w_fs ? r_frame_count[0] : r_view_fc0;

    // ---------------- bar tracking ----------------
    logic              w_scrolling;
    logic [c_BI_W-1:0] r_bar_idx, w_bar_idx;
    logic [c_BC_W-1:0] r_bar_cnt, w_bar_cnt;

    assign w_scrolling = (w_pattern == c_PAT_SCROLL);
    assign w_bar_idx   = w_ls ? (w_scrolling ? w_v_bar : '0) : r_bar_idx;
    assign w_bar_cnt   = w_ls ? (w_scrolling ? w_v_off : '0) : r_bar_cnt;

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_bar_idx <= '0;
            r_bar_cnt <= '0;
        end else if (data_enable) begin
            if (w_bar_cnt == c_BC_LAST) begin
                r_bar_cnt <= '0;
                if (w_bar_idx == c_BI_LAST)
                    r_bar_idx <= w_scrolling ? '0 : c_BI_LAST;
                else
                    r_bar_idx <= w_bar_idx + c_BI_W'(1);
            end else begin
                r_bar_idx <= w_bar_idx;
                r_bar_cnt <= w_bar_cnt + c_BC_W'(1);
            end
        end
    end

    // ---------------- red gradient ----------------
    logic [4:0] w_red;

    generate
        if (H_ACTIVE == (1 << X_W)) begin : g_grad_direct
            assign w_red = pixel_x[X_W-1 -: 5];
        end else begin : g_grad_count
            // acc holds 32*x mod H_ACTIVE, red holds floor(32*x / H_ACTIVE)
            logic [c_GA_W-1:0] r_grad_acc, w_g_acc, w_g_sum;
            logic [4:0]        r_grad_r;

            assign w_g_acc = w_ls ? '0 : r_grad_acc;
            assign w_red   = w_ls ? 5'd0 : r_grad_r;
            assign w_g_sum = w_g_acc + c_GA_W'(32);

            always_ff @(posedge clk_pixel or posedge rst) begin
                if (rst) begin
                    r_grad_acc <= '0;
                    r_grad_r   <= 5'd0;
                end else if (data_enable) begin
                    if (w_g_sum >= c_GA_W'(H_ACTIVE)) begin
                        r_grad_acc <= w_g_sum - c_GA_W'(H_ACTIVE);
                        r_grad_r   <= w_red + 5'd1;
                    end else begin
                        r_grad_acc <= w_g_sum;
                        r_grad_r   <= w_red;
                    end
                end
            end
        end
    endgenerate

    // ---------------- pattern select ----------------
    logic [15:0] w_pix, w_out;

    always_comb begin
        w_pix = 16'h0000;
        case (w_pattern)
            c_PAT_BARS, c_PAT_SCROLL: w_pix = f_bar_color(w_bar_idx[2:0]);
            c_PAT_RED:     w_pix = {w_red, 11'd0};
            c_PAT_GREEN:   w_pix = {5'd0, pixel_y[Y_W-2 -: 5], 1'b0, 5'd0};
            c_PAT_GRID: begin
                if ((pixel_x[GRID_LOG2-1:0] == '0) || (pixel_y[GRID_LOG2-1:0] == '0))
                    w_pix = w_color;
            end
            c_PAT_CHECK: begin
                if (pixel_x[GRID_LOG2] ^ pixel_y[GRID_LOG2])
                    w_pix = w_color;
            end
            c_PAT_SOLID:   w_pix = w_color;
            c_PAT_LINE: begin
                if (pixel_x == X_W'(w_v_pos))
                    w_pix = w_color;
            end
            c_PAT_FLICKER: begin
                if (!w_v_fc0)
                    w_pix = w_color;
            end
            default:       w_pix = 16'h0000;
        endcase
    end

`ifdef PATTERN_BORDER_EN
    always_comb begin
        w_out = w_pix;
        if ((pixel_x == '0) || (pixel_x == X_W'(H_ACTIVE - 1)) ||
            (pixel_y == '0) || (pixel_y == Y_W'(V_ACTIVE - 1)))
            w_out = 16'hFFFF;
    end
`else
    assign w_out = w_pix;
`endif

    // ---------------- output pipeline ----------------
    logic [15:0] r_s1_pix, r_rgb;
    logic        r_s1_de, r_valid;

    always_ff @(posedge clk_pixel or posedge rst) begin
        if (rst) begin
            r_s1_pix <= 16'h0000;
            r_s1_de  <= 1'b0;
            r_rgb    <= 16'h0000;
            r_valid  <= 1'b0;
        end else begin
            r_s1_pix <= data_enable ? w_out : 16'h0000;
            r_s1_de  <= data_enable;
            r_rgb    <= r_s1_de ? r_s1_pix : 16'h0000;
            r_valid  <= r_s1_de;
        end
    end

    assign rgb565       = r_rgb;
    assign rgb565_valid = r_valid;

endmodule
`default_nettype wire
